// File: rtl/inst_encoder_pkg.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg
// Shared RV32I definitions used by the instruction encoder and the immediate
// generator: major opcode constants, the instruction format enum, the
// opcode-to-format decode and a signed-range helper for immediates.
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_e;

   // Map a major opcode onto its encoding format; unknown opcodes are illegal.
   function automatic fmt_e opc_to_fmt(input logic [6:0] opc);
      fmt_e fmt;
      case (opc)
         OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
         OPC_STORE:                                 fmt = FMT_S;
         OPC_BRANCH:                                fmt = FMT_B;
         OPC_AUIPC, OPC_LUI:                        fmt = FMT_U;
         OPC_JAL:                                   fmt = FMT_J;
         OPC_OP:                                    fmt = FMT_R;
         default:                                   fmt = FMT_ILL;
      endcase
      return fmt;
   endfunction

   // True when v is representable as a signed value whose sign bit is v[msb],
   // i.e. bits [31:msb] are all copies of one another.
   function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
      logic signed [31:0] sh;
      sh = $signed(v) >>> msb;
      return (sh == 32'sd0) || (sh == -32'sd1);
   endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_if
// Field-bundle input stream and encoded-word output stream of the encoder.
//   master : program builder side (drives fields, in_valid, out_ready)
//   slave  : encoder side (drives in_ready, out_* and err_count)
// -----------------------------------------------------------------------------
interface inst_encoder_if #(
   parameter int ADDR_W = 14
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [2:0]        funct3;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [6:0]        funct7;
   logic [31:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;
   logic [7:0]        err_count;

   modport master (
      output in_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
   );

   modport slave (
      input  in_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err, err_count
   );
endinterface

// File: rtl/inst_encoder_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational: scatters instruction fields into an RV32I word and
// flags illegal opcodes or out-of-range / misaligned immediates.
//   opcode_i..imm_i : instruction fields
//   inst_o          : encoded word (0 for an illegal opcode)
//   err_o           : encoding error for this word
// -----------------------------------------------------------------------------
module inst_pack
   import inst_encoder_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [2:0]  funct3_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] inst_o,
   output logic        err_o
);

   fmt_e fmt_s;

   assign fmt_s = opc_to_fmt(opcode_i);

   // Field placement per format; the word keeps truncated immediate bits even
   // when the range check fails so the offending value is visible downstream.
   always_comb begin
      inst_o = 32'd0;
      err_o  = 1'b0;
      case (fmt_s)
         FMT_R: begin
            inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            err_o  = 1'b0;
         end
         FMT_I: begin
            inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            err_o  = !fits_signed(imm_i, 5'd11);
         end
         FMT_S: begin
            inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            err_o  = !fits_signed(imm_i, 5'd11);
         end
         FMT_B: begin
            inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
            // 13-bit signed range; the even constraint caps the top at 4094
            err_o  = !fits_signed(imm_i, 5'd12) || imm_i[0];
         end
         FMT_U: begin
            inst_o = {imm_i[31:12], rd_i, opcode_i};
            err_o  = (imm_i[11:0] != 12'd0);
         end
         FMT_J: begin
            inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            err_o  = !fits_signed(imm_i, 5'd20) || imm_i[0];
         end
         FMT_ILL: begin
            inst_o = 32'd0;
            err_o  = 1'b1;
         end
         default: begin
            inst_o = 32'd0;
            err_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Encodes RV32I field bundles into instruction words, tags each word with its
// IMEM byte address and streams it through a one-deep valid/ready stage.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : synchronous pulse; flushes the output stage, reloads the address
//           counter to BASE_ADDR and clears err_count
//   enc   : slave side of inst_encoder_if (fields in, encoded words out)
// -----------------------------------------------------------------------------
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   inst_encoder_if.slave  enc
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

   logic [31:0]       pack_inst_s;
   logic              pack_err_s;
   logic              in_ready_s;
   logic              xfer_s;

   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_inst_q,  out_inst_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic              out_err_q,   out_err_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [7:0]        err_count_q, err_count_d;

   inst_pack u_pack (
      .opcode_i (enc.opcode),
      .rd_i     (enc.rd),
      .funct3_i (enc.funct3),
      .rs1_i    (enc.rs1),
      .rs2_i    (enc.rs2),
      .funct7_i (enc.funct7),
      .imm_i    (enc.imm),
      .inst_o   (pack_inst_s),
      .err_o    (pack_err_s)
   );

   // The stage can take a word when empty or draining this cycle; start
   // blocks acceptance so the flush cannot race a new word.
   assign in_ready_s = !start && (!out_valid_q || enc.out_ready);
   assign xfer_s     = enc.in_valid && in_ready_s;

   // Next-state for the output stage, address counter and error counter.
   always_comb begin
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_addr_d  = out_addr_q;
      out_err_d   = out_err_q;
      next_addr_d = next_addr_q;
      err_count_d = err_count_q;
      if (start) begin
         out_valid_d = 1'b0;
         next_addr_d = BASE_A;
         err_count_d = 8'd0;
      end else if (xfer_s) begin
         out_valid_d = 1'b1;
         out_inst_d  = pack_inst_s;
         out_addr_d  = next_addr_q;
         out_err_d   = pack_err_s;
         next_addr_d = next_addr_q + STEP;
         if (pack_err_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end else begin
            err_count_d = err_count_q;
         end
      end else if (enc.out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers; reset drops any held word immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_inst_q  <= 32'd0;
         out_addr_q  <= BASE_A;
         out_err_q   <= 1'b0;
         next_addr_q <= BASE_A;
         err_count_q <= 8'd0;
      end else begin
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_addr_q  <= out_addr_d;
         out_err_q   <= out_err_d;
         next_addr_q <= next_addr_d;
         err_count_q <= err_count_d;
      end
   end

   assign enc.in_ready  = in_ready_s;
   assign enc.out_valid = out_valid_q;
   assign enc.out_inst  = out_inst_q;
   assign enc.out_addr  = out_addr_q;
   assign enc.out_err   = out_err_q;
   assign enc.err_count = err_count_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Encodes RISC-V instruction fields (opcode, registers, functs, full 32-bit immediate) into a 32-bit RV32I instruction word. It is the inverse of the core's immediate generator: it scatters the immediate into I/S/B/U/J bit positions. It sits between the test/boot program builder and the IMEM write port. It range-checks immediates, tags each output word with its IMEM byte address, and streams results through a one-deep valid/ready pipeline stage.

Parameters:
ADDR_W, 14, width of output byte address; the address counter wraps modulo 2^ADDR_W
BASE_ADDR, 0, byte address loaded on reset and on start; must be 4-byte aligned

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  pulse; reloads address counter to BASE_ADDR and clears err_count
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
opcode  input  7  inst[6:0]
rd  input  5  destination register
funct3  input  3  funct3
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  funct7 (R-type only)
imm  input  32  immediate as a two's-complement value (U: full value, low 12 bits must be 0)
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts the word
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_inst
out_err  output  1  this word has an illegal opcode or an out-of-range/misaligned immediate
err_count  output  8  saturating count of accepted words with out_err=1

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0, err_count=0, internal next-address counter=BASE_ADDR.
- Format from opcode:
  - 0x03/0x13/0x67/0x73 → I
  - 0x23 → S
  - 0x63 → B
  - 0x17/0x37 → U
  - 0x6F → J
  - 0x33 → R
  - any other opcode → illegal: out_err=1, out_inst=0.
- Encoding (fields not used by the format are zero):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Range checks (violation sets out_err=1; out_inst still carries truncated bits):
  - I/S: -2048..2047
  - B: -4096..4094 and imm[0]=0
  - J: -1048576..1048574 and imm[0]=0
  - U: imm[11:0]=0
  - R: imm ignored
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer occurs when in_valid && in_ready. Latency is 1 cycle: the encoded word is registered with out_valid=1 on the next edge.
  - out_addr takes the counter value, and the counter then advances by 4, wrapping at 2^ADDR_W.
  - While out_valid && !out_ready, out_inst/out_addr/out_err hold stable and in_ready=0.
  - Simultaneous drain and accept in the same cycle gives full throughput of one word per cycle.
- err_count increments on each transfer whose word has out_err=1, and saturates at 255.
- start:
  - Synchronous. Drops any registered word (out_valid=0), counter=BASE_ADDR, err_count=0.
  - in_ready=0 in the start cycle, so no transfer occurs.
- Reset mid-transfer drops the held word; no partial word is ever presented.

Decomposition:
- Shared package holds opcode constants (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_OP) and the format enum FMT_R/I/S/B/U/J/ILL. The immediate generator uses the same package.
- One combinational sub-module, inst_pack: fields → {inst, err}. The top holds the pipeline register, address counter and err_count.

Test Plan:
- addi x1,x0,5 (op 0x13, rd 1, f3 0, rs1 0, imm 5), out_ready=1 → out_inst=0x00500093, out_addr=0x0, out_err=0, one cycle latency.
- sw x2,-4(x1) (op 0x23, f3 2, rs1 1, rs2 2, imm 0xFFFFFFFC) then beq x0,x0,-8 (op 0x63, imm 0xFFFFFFF8), back-to-back → 0xFE20AE23 at addr 0x0, 0xFE000CE3 at addr 0x4, no bubbles.
- lui x5 with imm 0x12345000 → 0x123452B7, err=0; same with imm 0x12345001 → out_err=1, err_count=1. B imm=3 → err; J imm=0x100000 → err; opcode 0x7F → out_inst=0, err; err_count=4 total.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, outputs stable; release → words drain in order, addresses consecutive by 4.
- ADDR_W=4, 5 words → out_addr 0x0, 0x4, 0x8, 0xC, 0x0 (wrap); start pulse → next word at BASE_ADDR, err_count=0.
- Assert rst_n low while out_valid=1 and out_ready=0 → out_valid drops immediately (async); after release the first word is at BASE_ADDR.
